// File: rtl/conv_layer_controller_if.sv
// Handshake and RAM/PE control bundle between the conv layer sequencer and
// the datapath it drives. The controller side uses the master modport.
interface conv_layer_controller_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned N          = 5,
  parameter int unsigned IN_CH      = 1,
  parameter int unsigned OUT_CH     = 6
);
  localparam int unsigned LOC_W = (N * N > 32'd1) ? $clog2(N * N) : 32'd1;
  localparam int unsigned OC_W  = $clog2(OUT_CH) + 32'd1;
  localparam int unsigned IC_W  = $clog2(IN_CH) + 32'd1;

  logic                  start;
  logic                  stall;
  logic                  busy;
  logic                  done;
  logic                  ctrl_ram_en;
  logic                  ctrl_WorI;
  logic [1:0]            ctrl_mode;
  logic [ADDR_WIDTH-1:0] ctrl_read_addr;
  logic [LOC_W-1:0]      ctrl_weight_location;
  logic [OC_W-1:0]       ctrl_oc;
  logic [IC_W-1:0]       ctrl_ic;
  logic                  ctrl_acc_clear;
  logic                  ctrl_acc_last;

  modport master (
    input  start,
    input  stall,
    output busy,
    output done,
    output ctrl_ram_en,
    output ctrl_WorI,
    output ctrl_mode,
    output ctrl_read_addr,
    output ctrl_weight_location,
    output ctrl_oc,
    output ctrl_ic,
    output ctrl_acc_clear,
    output ctrl_acc_last
  );

  modport slave (
    output start,
    output stall,
    input  busy,
    input  done,
    input  ctrl_ram_en,
    input  ctrl_WorI,
    input  ctrl_mode,
    input  ctrl_read_addr,
    input  ctrl_weight_location,
    input  ctrl_oc,
    input  ctrl_ic,
    input  ctrl_acc_clear,
    input  ctrl_acc_last
  );
endinterface

// File: rtl/conv_layer_controller.sv
// Sequencer for one conv layer: for every (oc, ic) pair it reads the kernel,
// streams the input map and then waits for the MAC pipeline to drain.
// Every output is a register loaded from the next-state logic, so a change of
// phase is visible in the cycle right after the edge that decided it.
module conv_layer_controller #(
  parameter int unsigned           ADDR_WIDTH  = 12,
  parameter int unsigned           N           = 5,
  parameter int unsigned           IMG_W       = 28,
  parameter int unsigned           IMG_H       = 28,
  parameter int unsigned           IN_CH       = 1,
  parameter int unsigned           OUT_CH      = 6,
  parameter int unsigned           PIPE_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 12'd2048,
  parameter logic [ADDR_WIDTH-1:0] IMG_BASE    = 12'd0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  conv_layer_controller_if.master bus
);
  localparam int unsigned KK    = N * N;
  localparam int unsigned PIX   = IMG_W * IMG_H;
  localparam int unsigned LOC_W = (KK > 32'd1) ? $clog2(KK) : 32'd1;
  localparam int unsigned OC_W  = $clog2(OUT_CH) + 32'd1;
  localparam int unsigned IC_W  = $clog2(IN_CH) + 32'd1;
  localparam int unsigned P_W   = (PIX > 32'd1) ? $clog2(PIX) : 32'd1;
  localparam int unsigned D_W   = (PIPE_DEPTH > 32'd1) ? $clog2(PIPE_DEPTH) : 32'd1;

  localparam logic [LOC_W-1:0] K_LAST  = LOC_W'(KK - 32'd1);
  localparam logic [P_W-1:0]   P_LAST  = P_W'(PIX - 32'd1);
  localparam logic [D_W-1:0]   D_LAST  = D_W'(PIPE_DEPTH - 32'd1);
  localparam logic [OC_W-1:0]  OC_LAST = OC_W'(OUT_CH - 32'd1);
  localparam logic [IC_W-1:0]  IC_LAST = IC_W'(IN_CH - 32'd1);

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_LOAD_W = 2'd1;
  localparam logic [1:0] MODE_IMG    = 2'd2;
  localparam logic [1:0] MODE_DRAIN  = 2'd3;

  // Both RAM regions must fit below the top of the address space, otherwise
  // the walking pointers would wrap onto unrelated data.
  localparam longint ADDR_SPAN = 64'sd1 <<< ADDR_WIDTH;
  localparam longint W_END = longint'(WEIGHT_BASE) + longint'(OUT_CH) * longint'(IN_CH) * longint'(KK);
  localparam longint I_END = longint'(IMG_BASE) + longint'(IN_CH) * longint'(PIX);

  if (W_END > ADDR_SPAN) begin : g_weight_region_check
    $error("conv_layer_controller: weight region exceeds address space");
  end
  if (I_END > ADDR_SPAN) begin : g_image_region_check
    $error("conv_layer_controller: image region exceeds address space");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_IMG    = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [LOC_W-1:0]      k_r, k_nxt_s;
  logic [P_W-1:0]        p_r, p_nxt_s;
  logic [D_W-1:0]        d_r, d_nxt_s;
  logic [OC_W-1:0]       oc_r, oc_nxt_s;
  logic [IC_W-1:0]       ic_r, ic_nxt_s;
  // wptr_r/iptr_r always hold the next address to issue in their region.
  logic [ADDR_WIDTH-1:0] wptr_r, wptr_nxt_s;
  logic [ADDR_WIDTH-1:0] iptr_r, iptr_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  done_r, done_nxt_s;
  logic                  ram_en_r, ram_en_nxt_s;
  logic                  wori_r, wori_nxt_s;
  logic [1:0]            mode_r, mode_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_nxt_s;
  logic                  clr_r, clr_nxt_s;
  logic                  last_r, last_nxt_s;

  // Next-state, counter and output decode; a stalled edge issues nothing and holds position.
  always_comb begin
    state_nxt_s  = state_r;
    k_nxt_s      = k_r;
    p_nxt_s      = p_r;
    d_nxt_s      = d_r;
    oc_nxt_s     = oc_r;
    ic_nxt_s     = ic_r;
    wptr_nxt_s   = wptr_r;
    iptr_nxt_s   = iptr_r;
    busy_nxt_s   = busy_r;
    done_nxt_s   = 1'b0;
    ram_en_nxt_s = 1'b0;
    wori_nxt_s   = wori_r;
    mode_nxt_s   = mode_r;
    addr_nxt_s   = addr_r;
    clr_nxt_s    = 1'b0;
    last_nxt_s   = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt_s  = S_LOAD_W;
          oc_nxt_s     = {OC_W{1'b0}};
          ic_nxt_s     = {IC_W{1'b0}};
          k_nxt_s      = {LOC_W{1'b0}};
          iptr_nxt_s   = IMG_BASE;
          addr_nxt_s   = WEIGHT_BASE;
          wptr_nxt_s   = WEIGHT_BASE + ADDR_WIDTH'(1'b1);
          ram_en_nxt_s = 1'b1;
          wori_nxt_s   = 1'b1;
          mode_nxt_s   = MODE_LOAD_W;
          busy_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end

      S_LOAD_W: begin
        if (bus.stall) begin
          state_nxt_s = S_LOAD_W;
        end else if (k_r == K_LAST) begin
          state_nxt_s  = S_IMG;
          p_nxt_s      = {P_W{1'b0}};
          addr_nxt_s   = iptr_r;
          iptr_nxt_s   = iptr_r + ADDR_WIDTH'(1'b1);
          ram_en_nxt_s = 1'b1;
          wori_nxt_s   = 1'b0;
          mode_nxt_s   = MODE_IMG;
          clr_nxt_s    = (ic_r == {IC_W{1'b0}});
          last_nxt_s   = (ic_r == IC_LAST);
        end else begin
          k_nxt_s      = k_r + LOC_W'(1'b1);
          addr_nxt_s   = wptr_r;
          wptr_nxt_s   = wptr_r + ADDR_WIDTH'(1'b1);
          ram_en_nxt_s = 1'b1;
          wori_nxt_s   = 1'b1;
        end
      end

      S_IMG: begin
        if (bus.stall) begin
          state_nxt_s = S_IMG;
        end else if (p_r == P_LAST) begin
          state_nxt_s = S_DRAIN;
          d_nxt_s     = {D_W{1'b0}};
          mode_nxt_s  = MODE_DRAIN;
        end else begin
          p_nxt_s      = p_r + P_W'(1'b1);
          addr_nxt_s   = iptr_r;
          iptr_nxt_s   = iptr_r + ADDR_WIDTH'(1'b1);
          ram_en_nxt_s = 1'b1;
          clr_nxt_s    = (ic_r == {IC_W{1'b0}});
          last_nxt_s   = (ic_r == IC_LAST);
        end
      end

      S_DRAIN: begin
        if (d_r != D_LAST) begin
          d_nxt_s = d_r + D_W'(1'b1);
        end else if (ic_r != IC_LAST) begin
          // Next input channel: its image follows the previous one in RAM.
          ic_nxt_s     = ic_r + IC_W'(1'b1);
          state_nxt_s  = S_LOAD_W;
          k_nxt_s      = {LOC_W{1'b0}};
          addr_nxt_s   = wptr_r;
          wptr_nxt_s   = wptr_r + ADDR_WIDTH'(1'b1);
          ram_en_nxt_s = 1'b1;
          wori_nxt_s   = 1'b1;
          mode_nxt_s   = MODE_LOAD_W;
        end else if (oc_r != OC_LAST) begin
          // Next output channel: images restart, weights keep walking forward.
          ic_nxt_s     = {IC_W{1'b0}};
          oc_nxt_s     = oc_r + OC_W'(1'b1);
          iptr_nxt_s   = IMG_BASE;
          state_nxt_s  = S_LOAD_W;
          k_nxt_s      = {LOC_W{1'b0}};
          addr_nxt_s   = wptr_r;
          wptr_nxt_s   = wptr_r + ADDR_WIDTH'(1'b1);
          ram_en_nxt_s = 1'b1;
          wori_nxt_s   = 1'b1;
          mode_nxt_s   = MODE_LOAD_W;
        end else begin
          state_nxt_s = S_DONE;
          done_nxt_s  = 1'b1;
          busy_nxt_s  = 1'b0;
          ic_nxt_s    = {IC_W{1'b0}};
          oc_nxt_s    = {OC_W{1'b0}};
          k_nxt_s     = {LOC_W{1'b0}};
          iptr_nxt_s  = IMG_BASE;
          wptr_nxt_s  = WEIGHT_BASE;
          addr_nxt_s  = {ADDR_WIDTH{1'b0}};
          wori_nxt_s  = 1'b0;
          mode_nxt_s  = MODE_IDLE;
        end
      end

      S_DONE: begin
        state_nxt_s = S_IDLE;
        busy_nxt_s  = 1'b0;
      end

      default: begin
        state_nxt_s = S_IDLE;
        busy_nxt_s  = 1'b0;
        oc_nxt_s    = {OC_W{1'b0}};
        ic_nxt_s    = {IC_W{1'b0}};
        k_nxt_s     = {LOC_W{1'b0}};
        p_nxt_s     = {P_W{1'b0}};
        d_nxt_s     = {D_W{1'b0}};
        iptr_nxt_s  = IMG_BASE;
        wptr_nxt_s  = WEIGHT_BASE;
        addr_nxt_s  = {ADDR_WIDTH{1'b0}};
        wori_nxt_s  = 1'b0;
        mode_nxt_s  = MODE_IDLE;
      end
    endcase
  end

  // State, counters, pointers and output registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      k_r      <= {LOC_W{1'b0}};
      p_r      <= {P_W{1'b0}};
      d_r      <= {D_W{1'b0}};
      oc_r     <= {OC_W{1'b0}};
      ic_r     <= {IC_W{1'b0}};
      wptr_r   <= WEIGHT_BASE;
      iptr_r   <= IMG_BASE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ram_en_r <= 1'b0;
      wori_r   <= 1'b0;
      mode_r   <= MODE_IDLE;
      addr_r   <= {ADDR_WIDTH{1'b0}};
      clr_r    <= 1'b0;
      last_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      k_r      <= k_nxt_s;
      p_r      <= p_nxt_s;
      d_r      <= d_nxt_s;
      oc_r     <= oc_nxt_s;
      ic_r     <= ic_nxt_s;
      wptr_r   <= wptr_nxt_s;
      iptr_r   <= iptr_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
      ram_en_r <= ram_en_nxt_s;
      wori_r   <= wori_nxt_s;
      mode_r   <= mode_nxt_s;
      addr_r   <= addr_nxt_s;
      clr_r    <= clr_nxt_s;
      last_r   <= last_nxt_s;
    end
  end

  assign bus.busy                 = busy_r;
  assign bus.done                 = done_r;
  assign bus.ctrl_ram_en          = ram_en_r;
  assign bus.ctrl_WorI            = wori_r;
  assign bus.ctrl_mode            = mode_r;
  assign bus.ctrl_read_addr       = addr_r;
  assign bus.ctrl_weight_location = k_r;
  assign bus.ctrl_oc              = oc_r;
  assign bus.ctrl_ic              = ic_r;
  assign bus.ctrl_acc_clear       = clr_r;
  assign bus.ctrl_acc_last        = last_r;
endmodule

// File: tb/tb_conv_layer_controller.sv
// Bench for conv_layer_controller: per-cycle expected traces built from the
// address formulas for a small layer, plus a run of the default-size layer.
module tb_conv_layer_controller;
  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_W     = 2'd1;
  localparam logic [1:0] M_IMG   = 2'd2;
  localparam logic [1:0] M_DRAIN = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  conv_layer_controller_if #(.ADDR_WIDTH(12), .N(2), .IN_CH(2), .OUT_CH(2)) bus ();
  conv_layer_controller_if bus_d ();

  conv_layer_controller #(
    .ADDR_WIDTH(12), .N(2), .IMG_W(3), .IMG_H(2), .IN_CH(2), .OUT_CH(2),
    .PIPE_DEPTH(2), .WEIGHT_BASE(12'd100), .IMG_BASE(12'd0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  conv_layer_controller dut_d (
    .clk(clk), .rst_n(rst_n), .bus(bus_d)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        ram_en;
    logic        wori;
    logic [1:0]  mode;
    logic [11:0] addr;
    logic [1:0]  loc;
    logic [1:0]  oc;
    logic [1:0]  ic;
    logic        clr;
    logic        last;
  } trace_t;

  trace_t exp_q[$];
  trace_t msk_q[$];
  bit     stall_q[$];
  trace_t full_m;

  function automatic trace_t mk(input logic busy, input logic done, input logic en,
                                input logic wori, input logic [1:0] mode,
                                input logic [11:0] addr, input logic [1:0] loc,
                                input logic [1:0] oc, input logic [1:0] ic,
                                input logic clr, input logic last);
    trace_t t;
    t.busy = busy; t.done = done; t.ram_en = en; t.wori = wori; t.mode = mode;
    t.addr = addr; t.loc = loc; t.oc = oc; t.ic = ic; t.clr = clr; t.last = last;
    return t;
  endfunction

  function automatic trace_t sample();
    return mk(bus.busy, bus.done, bus.ctrl_ram_en, bus.ctrl_WorI, bus.ctrl_mode,
              bus.ctrl_read_addr, bus.ctrl_weight_location, bus.ctrl_oc, bus.ctrl_ic,
              bus.ctrl_acc_clear, bus.ctrl_acc_last);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Push one expected cycle; hold>0 appends that many stalled repeats of it.
  task automatic push(input trace_t r, input trace_t m, input int hold, input bit st);
    trace_t h;
    trace_t hm;
    if (hold == 0) begin
      exp_q.push_back(r); msk_q.push_back(m); stall_q.push_back(st);
    end else begin
      exp_q.push_back(r); msk_q.push_back(m); stall_q.push_back(1'b1);
      h = r; h.ram_en = 1'b0; h.clr = 1'b0; h.last = 1'b0;
      hm = m; hm.wori = 1'b0;
      for (int i = 1; i <= hold; i++) begin
        exp_q.push_back(h); msk_q.push_back(hm); stall_q.push_back(i < hold);
      end
    end
  endtask

  // Expected trace of the small layer, starting at the first LOAD_W cycle.
  task automatic build(input bit st_img3, input bit st_w102, input bit st_drain);
    trace_t r;
    trace_t m;
    exp_q.delete(); msk_q.delete(); stall_q.delete();
    for (int oc = 0; oc < 2; oc++) begin
      for (int ic = 0; ic < 2; ic++) begin
        for (int k = 0; k < 4; k++) begin
          r = mk(1'b1, 1'b0, 1'b1, 1'b1, M_W, 12'(100 + (oc * 2 + ic) * 4 + k),
                 2'(k), 2'(oc), 2'(ic), 1'b0, 1'b0);
          push(r, full_m, (st_w102 && oc == 0 && ic == 0 && k == 2) ? 1 : 0, 1'b0);
        end
        for (int p = 0; p < 6; p++) begin
          r = mk(1'b1, 1'b0, 1'b1, 1'b0, M_IMG, 12'(ic * 6 + p), 2'd0, 2'(oc), 2'(ic),
                 ic == 0, ic == 1);
          m = full_m; m.loc = 2'd0;
          push(r, m, (st_img3 && oc == 0 && ic == 0 && p == 3) ? 3 : 0, 1'b0);
        end
        for (int d = 0; d < 2; d++) begin
          r = mk(1'b1, 1'b0, 1'b0, 1'b0, M_DRAIN, 12'd0, 2'd0, 2'(oc), 2'(ic), 1'b0, 1'b0);
          m = full_m; m.wori = 1'b0; m.addr = 12'd0; m.loc = 2'd0;
          push(r, m, 0, st_drain && oc == 0 && ic == 0);
        end
      end
    end
    r = mk(1'b0, 1'b1, 1'b0, 1'b0, M_IDLE, 12'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    m = '0; m.busy = 1'b1; m.done = 1'b1; m.ram_en = 1'b1; m.clr = 1'b1; m.last = 1'b1;
    push(r, m, 0, 1'b0);
    r = '0;
    m = full_m; m.wori = 1'b0; m.addr = 12'd0; m.loc = 2'd0;
    push(r, m, 0, 1'b0);
  endtask

  // Pulse start, then compare every cycle against the expected trace.
  task automatic run_seq(input string tag, input bit start_stall, input int restart_at,
                         input int abort_at);
    trace_t a;
    @(negedge clk);
    bus.start = 1'b1;
    bus.stall = start_stall;
    @(posedge clk);
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      a = sample();
      checks++;
      if (((a ^ exp_q[c]) & msk_q[c]) != '0) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h want %h (mask %h)", tag, c, a, exp_q[c], msk_q[c]);
      end
      bus.start = (c == restart_at);
      bus.stall = stall_q[c];
      if (c == abort_at) begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int busy_cnt;
    int dones;
    int bad;
    int img_reads;
    int post;
    logic [11:0] last_w;
    logic [11:0] last_i;

    full_m = '1;
    bus.start = 1'b0; bus.stall = 1'b0;
    bus_d.start = 1'b0; bus_d.stall = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'(sample()), 64'd0);
    chk("reset_outputs_default",
        64'({bus_d.busy, bus_d.done, bus_d.ctrl_ram_en, bus_d.ctrl_WorI, bus_d.ctrl_mode,
             bus_d.ctrl_read_addr, bus_d.ctrl_weight_location, bus_d.ctrl_oc, bus_d.ctrl_ic,
             bus_d.ctrl_acc_clear, bus_d.ctrl_acc_last}), 64'd0);
    rst_n = 1'b1;

    build(1'b0, 1'b0, 1'b0);
    run_seq("s1_plain", 1'b0, -1, -1);

    build(1'b1, 1'b0, 1'b0);
    run_seq("s2_stall_img", 1'b0, -1, -1);

    build(1'b0, 1'b1, 1'b1);
    run_seq("s3_stall_w_drain", 1'b0, -1, -1);

    build(1'b0, 1'b0, 1'b0);
    run_seq("s4_restart_ignored", 1'b1, 20, -1);

    build(1'b0, 1'b0, 1'b0);
    run_seq("s5_abort", 1'b0, -1, 30);
    @(negedge clk);
    chk("s5_after_reset_zero", 64'(sample()), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s5_no_done", 64'(bus.done), 64'd0);
    end
    run_seq("s5_restart", 1'b0, -1, -1);

    // Default-size layer on the second instance.
    busy_cnt = 0; dones = 0; bad = 0; img_reads = 0; post = 0;
    last_w = 12'd0; last_i = 12'd0;
    @(negedge clk);
    bus_d.start = 1'b1;
    @(negedge clk);
    bus_d.start = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      if (bus_d.busy) busy_cnt++;
      if (bus_d.ctrl_ram_en && bus_d.ctrl_WorI) last_w = bus_d.ctrl_read_addr;
      if (bus_d.ctrl_ram_en && !bus_d.ctrl_WorI) begin
        last_i = bus_d.ctrl_read_addr;
        img_reads++;
        if (!(bus_d.ctrl_acc_clear && bus_d.ctrl_acc_last)) bad++;
      end
      if (!bus_d.ctrl_ram_en && (bus_d.ctrl_acc_clear || bus_d.ctrl_acc_last)) bad++;
      if (bus_d.done) dones++;
      if (dones > 0) post++;
      if (post > 4) break;
      @(negedge clk);
    end
    chk("s6_done_pulses", 64'(dones), 64'd1);
    chk("s6_busy_cycles", 64'(busy_cnt), 64'd4878);
    chk("s6_last_weight_addr", 64'(last_w), 64'd2197);
    chk("s6_last_img_addr", 64'(last_i), 64'd783);
    chk("s6_img_reads", 64'(img_reads), 64'd4704);
    chk("s6_acc_flags", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
